// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD snapshot bank.
package bcd_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic {
    ST_LIVE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Index width for a history of 'depth' slots (at least one bit).
  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a level key input: one register plus an AND gate.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic pulse
);

  logic prev;

  // Remember last cycle's level; resets low so a key already held at reset
  // release produces a pulse on the first clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= in;
  end

  assign pulse = in & ~prev;

endmodule

// File: rtl/bcd_snapshot_bank.sv
// Display snapshot store: LIVE pass-through, HOLD on save, circular history
// of the last DEPTH saved readings that can be stepped newest-to-oldest.
// The FSM state is visible on the 'hold' output (1 = ST_HOLD).
module bcd_snapshot_bank
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DEPTH  = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DIGIT_W*DIGITS-1:0]      din,
  input  logic                           save,
  input  logic                           next,
  input  logic                           resume,
  input  logic                           clear,
  output logic [DIGIT_W*DIGITS-1:0]      dout,
  output logic                           hold,
  output logic [ptr_w(DEPTH)-1:0]        view_idx,
  output logic [ptr_w(DEPTH):0]          count,
  output logic                           full
);

  localparam int DW = DIGIT_W * DIGITS;
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  state_t          state, state_n;
  logic [DW-1:0]   dout_n;
  logic [PW-1:0]   view_n;
  logic [CW-1:0]   count_n;
  logic [PW-1:0]   wr_ptr, wr_n;
  logic            we;
  logic            capture;
  logic [CW-1:0]   view_inc;
  logic [PW-1:0]   step_view;
  logic [PW-1:0]   rd_idx;

  logic [DW-1:0]   mem [DEPTH];

  rise_detect u_save_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (save),
    .pulse (capture)
  );

  // View stepping wraps at the number of valid snapshots, not at DEPTH.
  assign view_inc  = {1'b0, view_idx} + 1'b1;
  assign step_view = (view_inc == count) ? '0 : view_inc[PW-1:0];
  // Age 0 is the slot just behind the write pointer; wraps modulo DEPTH.
  assign rd_idx    = wr_ptr - 1'b1 - step_view;

  // Next-state and output decode; priority clear > capture > resume > next.
  always_comb begin
    state_n = state;
    dout_n  = (state == ST_LIVE) ? din : dout;
    view_n  = view_idx;
    count_n = count;
    wr_n    = wr_ptr;
    we      = 1'b0;
    if (clear) begin
      state_n = ST_LIVE;
      dout_n  = din;
      view_n  = '0;
      count_n = '0;
      wr_n    = '0;
    end else if (capture) begin
      we      = 1'b1;
      state_n = ST_HOLD;
      dout_n  = din;
      view_n  = '0;
      wr_n    = wr_ptr + 1'b1;
      count_n = (count == CNT_MAX) ? count : count + 1'b1;
    end else if (resume && state == ST_HOLD) begin
      state_n = ST_LIVE;
      dout_n  = din;
    end else if (next && state == ST_HOLD) begin
      view_n  = step_view;
      dout_n  = mem[rd_idx];
    end
  end

  // Control and display registers; reset is immediate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_LIVE;
      dout     <= '0;
      view_idx <= '0;
      count    <= '0;
      wr_ptr   <= '0;
    end else begin
      state    <= state_n;
      dout     <= dout_n;
      view_idx <= view_n;
      count    <= count_n;
      wr_ptr   <= wr_n;
    end
  end

  // History storage: written only on capture, never reset or erased.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= din;
  end

  assign hold = (state == ST_HOLD);
  assign full = (count == CNT_MAX);

endmodule

// File: tb/tb_bcd_snapshot_bank.sv
// Directed bench for bcd_snapshot_bank (DIGITS=4, DEPTH=8).
module tb_bcd_snapshot_bank;

  logic        clk;
  logic        rst_n;
  logic [15:0] din;
  logic        save, next, resume, clear;
  logic [15:0] dout;
  logic        hold;
  logic [2:0]  view_idx;
  logic [3:0]  count;
  logic        full;

  int checks   = 0;
  int failures = 0;

  bcd_snapshot_bank #(.DIGITS(4), .DEPTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .save     (save),
    .next     (next),
    .resume   (resume),
    .clear    (clear),
    .dout     (dout),
    .hold     (hold),
    .view_idx (view_idx),
    .count    (count),
    .full     (full)
  );

  // Clock: 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e_dout, input logic e_hold,
                         input logic [2:0] e_view, input logic [3:0] e_count, input logic e_full);
    chk({tag, ".dout"},     32'(dout),     32'(e_dout));
    chk({tag, ".hold"},     32'(hold),     32'(e_hold));
    chk({tag, ".view_idx"}, 32'(view_idx), 32'(e_view));
    chk({tag, ".count"},    32'(count),    32'(e_count));
    chk({tag, ".full"},     32'(full),     32'(e_full));
  endtask

  // Advance one clock; sample point is 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single capture: one cycle with save high, one with save low.
  task automatic cap(input logic [15:0] val);
    din  = val;
    save = 1'b1;
    step();
    save = 1'b0;
    step();
  endtask

  logic [15:0] exp_v;

  initial begin
    rst_n = 1'b0; din = 16'h0; save = 1'b0; next = 1'b0; resume = 1'b0; clear = 1'b0;
    repeat (3) step();
    chk_all("reset", 16'h0000, 1'b0, 3'd0, 4'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    din   = 16'h1234;

    // LIVE tracks din with one-cycle latency
    step();
    chk_all("live1", 16'h1234, 1'b0, 3'd0, 4'd0, 1'b0);
    din = 16'h5678;
    step();
    chk_all("live2", 16'h5678, 1'b0, 3'd0, 4'd0, 1'b0);

    // Save held high for 5 cycles: exactly one capture, din changes hidden
    din  = 16'h0042;
    save = 1'b1;
    step();
    chk_all("cap42", 16'h0042, 1'b1, 3'd0, 4'd1, 1'b0);
    din = 16'h9999;
    repeat (4) step();
    chk_all("cap42_held", 16'h0042, 1'b1, 3'd0, 4'd1, 1'b0);
    save = 1'b0;
    step();

    // Clear returns to LIVE with empty history
    din   = 16'h0100;
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk_all("clear1", 16'h0100, 1'b0, 3'd0, 4'd0, 1'b0);

    // Three captures then back-to-back next pulses wrap at count
    cap(16'h0001);
    cap(16'h0002);
    cap(16'h0003);
    chk_all("cap3", 16'h0003, 1'b1, 3'd0, 4'd3, 1'b0);
    next = 1'b1;
    step();
    chk_all("next1", 16'h0002, 1'b1, 3'd1, 4'd3, 1'b0);
    step();
    chk_all("next2", 16'h0001, 1'b1, 3'd2, 4'd3, 1'b0);
    step();
    chk_all("next3", 16'h0003, 1'b1, 3'd0, 4'd3, 1'b0);
    next = 1'b0;

    // Asynchronous reset between edges while in HOLD with count=3
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 16'h0000, 1'b0, 3'd0, 4'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    din   = 16'h4321;
    step();
    chk_all("post_rst", 16'h4321, 1'b0, 3'd0, 4'd0, 1'b0);

    // Fill past DEPTH: nine captures, oldest (0001) overwritten
    for (int i = 1; i <= 9; i++) begin
      cap(16'(i));
      if (i == 7) chk_all("cap7", 16'h0007, 1'b1, 3'd0, 4'd7, 1'b0);
      if (i == 8) chk_all("cap8", 16'h0008, 1'b1, 3'd0, 4'd8, 1'b1);
    end
    chk_all("cap9", 16'h0009, 1'b1, 3'd0, 4'd8, 1'b1);
    next = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      exp_v = 16'(9 - k);
      chk_all("full_step", exp_v, 1'b1, 3'(k), 4'd8, 1'b1);
    end
    step();
    chk_all("full_wrap", 16'h0009, 1'b1, 3'd0, 4'd8, 1'b1);
    next = 1'b0;

    // Resume returns to LIVE, history kept
    resume = 1'b1;
    din    = 16'h0abc;
    step();
    resume = 1'b0;
    chk_all("resume", 16'h0abc, 1'b0, 3'd0, 4'd8, 1'b1);
    din = 16'h0def;
    step();
    chk_all("live3", 16'h0def, 1'b0, 3'd0, 4'd8, 1'b1);

    // next and resume in LIVE are ignored
    next   = 1'b1;
    resume = 1'b1;
    din    = 16'h0321;
    step();
    next   = 1'b0;
    resume = 1'b0;
    chk_all("live_ignore", 16'h0321, 1'b0, 3'd0, 4'd8, 1'b1);

    // clear and save edge together: clear wins, nothing captured
    din   = 16'h0777;
    clear = 1'b1;
    save  = 1'b1;
    step();
    clear = 1'b0;
    chk_all("clear_vs_save", 16'h0777, 1'b0, 3'd0, 4'd0, 1'b0);
    din = 16'h0778;
    step();
    chk_all("save_still_high", 16'h0778, 1'b0, 3'd0, 4'd0, 1'b0);
    save = 1'b0;
    step();

    // capture beats resume in HOLD
    cap(16'h0555);
    din    = 16'h0666;
    save   = 1'b1;
    resume = 1'b1;
    step();
    save   = 1'b0;
    resume = 1'b0;
    chk_all("cap_vs_resume", 16'h0666, 1'b1, 3'd0, 4'd2, 1'b0);

    // resume beats next in HOLD
    din    = 16'h0888;
    resume = 1'b1;
    next   = 1'b1;
    step();
    resume = 1'b0;
    next   = 1'b0;
    chk_all("resume_vs_next", 16'h0888, 1'b0, 3'd0, 4'd2, 1'b0);

    // Non-BCD digits pass through unchanged, and history step reaches it
    cap(16'hfa9b);
    chk_all("non_bcd", 16'hfa9b, 1'b1, 3'd0, 4'd3, 1'b0);
    next = 1'b1;
    step();
    chk_all("non_bcd_step", 16'h0666, 1'b1, 3'd1, 4'd3, 1'b0);
    step();
    chk_all("non_bcd_step2", 16'h0555, 1'b1, 3'd2, 4'd3, 1'b0);
    next = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_snapshot_bank.md
# bcd_snapshot_bank

Parametrised, clocked snapshot store for multi-digit BCD display values. It sits between the counter/measurement datapath and the seven-segment scan driver. In LIVE mode it passes the current reading through; on a save request it freezes the display. It also keeps a circular history of the last DEPTH saved readings, which the user can step through and then resume from.

## Interface
- DIGITS, 4, number of BCD digits per reading (1..8)
- DEPTH, 8, number of stored snapshots (power of two, 2..16)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- din  in  4*DIGITS  live reading, digit 0 (ones) in bits [3:0], most significant digit in the top nibble
- save  in  1  level input (debounced key); its rising edge requests a capture
- next  in  1  one-cycle pulse; steps the view to the next-older snapshot while in HOLD
- resume  in  1  one-cycle pulse; returns to LIVE
- clear  in  1  one-cycle pulse; empties the history and returns to LIVE
- dout  out  4*DIGITS  displayed reading (registered)
- hold  out  1  1 in HOLD, 0 in LIVE
- view_idx  out  clog2(DEPTH)  age of the displayed snapshot: 0 = newest
- count  out  clog2(DEPTH)+1  number of valid snapshots, saturates at DEPTH
- full  out  1  count == DEPTH

## Operation
- States: LIVE, HOLD.
- Reset values:
  - state LIVE
  - dout all zero
  - hold 0
  - view_idx 0
  - count 0
  - full 0
  - write pointer 0
  - stored save value 0
  - storage contents don't-care
- Capture event: save is 1 in the current cycle and was 0 in the previous cycle (previous-value register resets to 0). A save already high when rst_n deasserts therefore captures on the first clock.
- LIVE:
  - dout <= din every cycle.
  - On capture: write din to slot wr_ptr; wr_ptr <= wr_ptr+1 (wraps modulo DEPTH); count <= min(count+1, DEPTH); dout <= din; view_idx <= 0; go to HOLD.
- HOLD:
  - dout holds the value of the selected snapshot.
  - next: view_idx <= (view_idx+1) mod count; dout <= slot[(wr_ptr-1-new_view_idx) mod DEPTH].
  - Capture in HOLD: stores the current din exactly as in LIVE and shows it (view_idx 0); stays in HOLD.
  - resume: go to LIVE; dout follows din from the next edge; history kept.
- When full, a capture overwrites the oldest slot; count stays DEPTH.
- clear, from any state: count <= 0, wr_ptr <= 0, view_idx <= 0, go to LIVE, dout <= din. Storage is not erased.
- Priority when events coincide in one cycle: clear > capture > resume > next. Lower-priority events in that cycle are dropped.
- next while in LIVE is ignored. resume while in LIVE is ignored.
- Digit values above 9 are stored and shown unchanged; there is no validation.
- Arithmetic: all pointer and index arithmetic is modulo DEPTH. count is kept at full width so that the value DEPTH is representable.

## Timing
- All outputs are registered. Every event takes effect on the output at the same rising edge at which it is sampled (one-cycle latency from input to output).
- save needs no minimum high time beyond one cycle. Holding save high gives exactly one capture; another capture needs save to go low for at least one cycle.
- Back-to-back next pulses step one snapshot per cycle.
- rst_n assertion mid-operation clears all state immediately (asynchronously), with no wait for a clock. Deassertion is expected to be synchronised externally.

## Structure
- Shared package `bcd_pkg`:
  - DIGIT_W = 4
  - state type {ST_LIVE, ST_HOLD}
  - a function returning the pointer width for a given DEPTH
- Sub-module `rise_detect` (clk, rst_n, in, pulse): one register plus AND gate; reused by the key-handling blocks.
- Storage is a DEPTH × 4*DIGITS register array with a write-enable on capture only. No RAM inference is required.

## Test plan
- Reset, then din=16'h1234 with no events → dout tracks din with 1-cycle latency; hold=0, count=0.
- din=16'h0042, raise save and keep it high for 5 cycles → exactly one capture; dout=16'h0042, hold=1, count=1; changes on din are not shown.
- Capture 16'h0001, 16'h0002, 16'h0003, then pulse next 3 times → dout shows 0003, 0002, 0001, 0003; view_idx shows 0, 1, 2, 0.
- DEPTH=8: capture 16'h0001..16'h0009 → count=8, full=1; stepping through all eight snapshots never shows 0001; the oldest shown is 0002.
- In the same cycle assert clear and a save rising edge → clear wins: count=0, hold=0, dout=din; nothing is stored.
- In HOLD with count=3, assert rst_n=0 between clock edges → outputs go to zero and LIVE immediately; after release, dout tracks din.
